// File: rtl/mprj_bram_arb.sv
// mprj_bram_arb: arbiter for the single-port user-project BRAM (mprjram).
// It shares the BRAM between the management CPU Wishbone port and the DMA
// engine. Every access runs issue -> fixed-latency wait -> ack. The DMA engine
// keeps the BRAM locked for a whole burst, but it must yield after MAX_BURST
// beats while the CPU is waiting, so CPU instruction fetch is never starved.
// Optional statistics counters are built when MPRJ_BRAM_ARB_STATS_EN is defined.
module mprj_bram_arb #(
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_sel,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic              dma_last,
    output logic              dma_ack,
    output logic [31:0]       dma_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata,
    output logic [1:0]        grant_o,
    output logic [15:0]       stat_cpu_stall,
    output logic [15:0]       stat_dma_beats
);

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_DMA  = 2'b10;
    localparam logic [2:0] WAIT_LAST  = 3'(RD_LAT - 1);
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK,
        ST_DMA_HOLD
    } state_t;

    state_t      state;
    logic        favor_dma;
    logic [7:0]  beat_cnt;
    logic [7:0]  beat_next;
    logic [2:0]  wait_cnt;
    logic        cur_we;

    // Beat count that includes the beat being acknowledged, saturating so it cannot wrap
    assign beat_next = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;

    // Arbitration and access-sequencing FSM; every output is a register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state      <= ST_IDLE;
            favor_dma  <= 1'b0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            cur_we     <= 1'b0;
            grant_o    <= GRANT_NONE;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_en <= 1'b0;
            bram_we <= '0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req && (!dma_req || !favor_dma)) begin
                        state      <= ST_ISSUE;
                        grant_o    <= GRANT_CPU;
                        cur_we     <= cpu_we;
                        bram_en    <= 1'b1;
                        bram_we    <= cpu_we ? cpu_sel : 4'h0;
                        bram_addr  <= cpu_addr;
                        bram_wdata <= cpu_wdata;
                    end else if (dma_req) begin
                        state      <= ST_ISSUE;
                        grant_o    <= GRANT_DMA;
                        cur_we     <= dma_we;
                        bram_en    <= 1'b1;
                        bram_we    <= dma_we ? 4'hF : 4'h0;
                        bram_addr  <= dma_addr;
                        bram_wdata <= dma_wdata;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    if (cur_we) begin
                        state <= ST_ACK;
                        if (grant_o == GRANT_CPU) begin
                            cpu_ack <= 1'b1;
                        end else begin
                            dma_ack <= 1'b1;
                        end
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_ACK;
                        if (grant_o == GRANT_CPU) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= bram_rdata;
                        end else begin
                            dma_ack   <= 1'b1;
                            dma_rdata <= bram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_ACK: begin
                    if (grant_o == GRANT_CPU) begin
                        state     <= ST_IDLE;
                        grant_o   <= GRANT_NONE;
                        favor_dma <= 1'b1;
                    end else begin
                        favor_dma <= 1'b0;
                        if (dma_last || (cpu_req && (beat_next >= BURST_MAX))) begin
                            state    <= ST_IDLE;
                            grant_o  <= GRANT_NONE;
                            beat_cnt <= '0;
                        end else begin
                            state    <= ST_DMA_HOLD;
                            beat_cnt <= beat_next;
                        end
                    end
                end
                ST_DMA_HOLD: begin
                    if (dma_req) begin
                        state      <= ST_ISSUE;
                        cur_we     <= dma_we;
                        bram_en    <= 1'b1;
                        bram_we    <= dma_we ? 4'hF : 4'h0;
                        bram_addr  <= dma_addr;
                        bram_wdata <= dma_wdata;
                    end else begin
                        state    <= ST_IDLE;
                        grant_o  <= GRANT_NONE;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= GRANT_NONE;
                end
            endcase
        end
    end

`ifdef MPRJ_BRAM_ARB_STATS_EN
    // Saturating counters for CPU wait cycles and completed DMA beats
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            stat_cpu_stall <= '0;
            stat_dma_beats <= '0;
        end else begin
            if (cpu_req && (grant_o != GRANT_CPU) && (stat_cpu_stall != 16'hFFFF)) begin
                stat_cpu_stall <= stat_cpu_stall + 16'd1;
            end
            if (dma_ack && (stat_dma_beats != 16'hFFFF)) begin
                stat_dma_beats <= stat_dma_beats + 16'd1;
            end
        end
    end
`else
    assign stat_cpu_stall = '0;
    assign stat_dma_beats = '0;
`endif

endmodule
